// File: rtl/read_memory_controller.sv
// read_memory_controller: one valid/ready read request becomes one memory read strobe and one presented word.
// Optional READ_BURST_EN adds burst_len/out_last and multi-word bursts with a wrapping address.
module read_memory_controller #(
    parameter int ADD_SIZE     = 12,
    parameter int DATA_SIZE    = 108,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADD_SIZE-1:0]  address_in,
`ifdef READ_BURST_EN
    input  logic [3:0]           burst_len,
    output logic                 out_last,
`endif
    output logic                 read_en_out,
    output logic [ADD_SIZE-1:0]  address_out,
    input  logic [DATA_SIZE-1:0] dataIn,
    output logic [DATA_SIZE-1:0] dataOut,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           dbg_state
);

    // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until that edge, and ready never depends on valid combinationally.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADD_SIZE-1:0]   addr_q, addr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  read_en_q, read_en_d;
    logic [ADD_SIZE-1:0]   address_out_q, address_out_d;
    logic [DATA_SIZE-1:0]  data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  accept;
    logic                  out_fire;
    logic                  beat_more;

`ifdef READ_BURST_EN
    logic [3:0]            beats_q, beats_d;
    logic                  out_last_q, out_last_d;

    assign beat_more = (beats_q != 4'd0);
`else
    assign beat_more = 1'b0;
`endif

    assign accept   = in_valid && in_ready_q && (state_q == S_IDLE);
    assign out_fire = out_valid_q && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_READ;
            S_READ:   state_d = S_WAIT;
            S_WAIT:   if (cnt_q == 4'd0) state_d = S_RESULT;
            S_RESULT: if (out_fire) state_d = beat_more ? S_READ : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are derived from the next state so they are registered.
    always_comb begin
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        address_out_d = address_out_q;
        data_out_d    = data_out_q;
        in_ready_d    = (state_d == S_IDLE);
        read_en_d     = (state_d == S_READ);
        out_valid_d   = (state_d == S_RESULT);
`ifdef READ_BURST_EN
        beats_d       = beats_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = address_in;
`ifdef READ_BURST_EN
                    beats_d = burst_len;
`endif
                end
            end
            S_READ: begin
                cnt_d = LAT_LOAD;
            end
            S_WAIT: begin
                // The memory word is valid only in this one cycle.
                if (cnt_q == 4'd0) begin
                    data_out_d = dataIn;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESULT: begin
                if (out_fire && beat_more) begin
                    addr_d = ADD_SIZE'(addr_q + 1'b1);
`ifdef READ_BURST_EN
                    beats_d = beats_q - 4'd1;
`endif
                end
            end
            default: ;
        endcase
        if (state_d == S_READ) begin
            address_out_d = addr_d;
        end
`ifdef READ_BURST_EN
        out_last_d = (state_d == S_RESULT) && (beats_d == 4'd0);
`endif
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= 4'd0;
            addr_q        <= '0;
            in_ready_q    <= 1'b0;
            read_en_q     <= 1'b0;
            address_out_q <= '0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
`ifdef READ_BURST_EN
            beats_q       <= 4'd0;
            out_last_q    <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            in_ready_q    <= in_ready_d;
            read_en_q     <= read_en_d;
            address_out_q <= address_out_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
`ifdef READ_BURST_EN
            beats_q       <= beats_d;
            out_last_q    <= out_last_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign read_en_out = read_en_q;
    assign address_out = address_out_q;
    assign dataOut     = data_out_q;
    assign out_valid   = out_valid_q;
    assign dbg_state   = state_q;
`ifdef READ_BURST_EN
    assign out_last    = out_last_q;
`endif

endmodule

// File: tb/tb_read_memory_controller.sv
// Bench for read_memory_controller: two instances (latency 1 and 3) against a cycle-level memory and
// transaction model; READ_BURST_EN enables the burst scenarios.
module tb_read_memory_controller;

    localparam int AW   = 12;
    localparam int DW   = 108;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst         [2];
    logic          in_valid    [2];
    logic          in_ready    [2];
    logic [AW-1:0] address_in  [2];
    logic          read_en     [2];
    logic [AW-1:0] address_out [2];
    logic [DW-1:0] data_in     [2];
    logic [DW-1:0] data_out    [2];
    logic          out_valid   [2];
    logic          out_ready   [2];
    logic [1:0]    dbg_state   [2];
`ifdef READ_BURST_EN
    logic [3:0]    burst_len   [2];
    logic          out_last    [2];
`endif

    read_memory_controller #(.ADD_SIZE(AW), .DATA_SIZE(DW), .READ_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .address_in(address_in[0]),
`ifdef READ_BURST_EN
        .burst_len(burst_len[0]), .out_last(out_last[0]),
`endif
        .read_en_out(read_en[0]), .address_out(address_out[0]), .dataIn(data_in[0]),
        .dataOut(data_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .dbg_state(dbg_state[0])
    );

    read_memory_controller #(.ADD_SIZE(AW), .DATA_SIZE(DW), .READ_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .address_in(address_in[1]),
`ifdef READ_BURST_EN
        .burst_len(burst_len[1]), .out_last(out_last[1]),
`endif
        .read_en_out(read_en[1]), .address_out(address_out[1]), .dataIn(data_in[1]),
        .dataOut(data_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .dbg_state(dbg_state[1])
    );

    // Shared memory contents and bench bookkeeping
    logic [DW-1:0] mem [4096];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            tmo_cnt = 0;
    int            bp_mode = 0;
    logic          end_req = 1'b0;
    logic          end_done = 1'b0;

    // Reference model state, per instance
    logic [DW-1:0] exp_q [$];
    logic          busy [2];
    logic          in_result [2];
    logic          started [2] = '{1'b0, 1'b0};
    logic          rst_prev [2] = '{1'b0, 1'b0};
    int            exp_strobe_cyc [2] = '{-1, -1};
    int            exp_valid_cyc [2] = '{-1, -1};
    logic [AW-1:0] exp_addr [2];
    int            beats_left [2] = '{0, 0};
    logic [DW-1:0] cur_exp [2];
    int            strobes_seen [2] = '{0, 0};
    int            strobes_exp [2] = '{0, 0};
    logic          hist_v [2][16];
    logic [AW-1:0] hist_a [2][16];
    int            m_lat;
    logic          m_rdy;
    logic          m_ok;

    function automatic logic [DW-1:0] rand_word();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    task automatic check(input string name, input int d, input logic [127:0] act, input logic [127:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp_v);
        end
    endtask

    // Backpressure driver: 0 = always ready, 1 = random, 2 = held low
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            case (bp_mode)
                0:       out_ready[d] = 1'b1;
                1:       out_ready[d] = ($urandom_range(0, 3) != 0);
                default: out_ready[d] = 1'b0;
            endcase
        end
    end

    // Memory model plus scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_lat = (d == 0) ? LAT0 : LAT1;
            for (int k = 15; k > 0; k--) begin
                hist_v[d][k] = hist_v[d][k-1];
                hist_a[d][k] = hist_a[d][k-1];
            end
            hist_v[d][0] = read_en[d];
            hist_a[d][0] = address_out[d];
            // Data is only meaningful exactly m_lat cycles after the strobe; otherwise noise.
            data_in[d] = (hist_v[d][m_lat] === 1'b1) ? mem[hist_a[d][m_lat]] : rand_word();

            if (started[d] && rst_prev[d]) begin
`ifdef READ_BURST_EN
                check("reset_outputs", d, 128'({in_ready[d], read_en[d], address_out[d], out_valid[d], out_last[d], data_out[d]}), 128'(0));
`else
                check("reset_outputs", d, 128'({in_ready[d], read_en[d], address_out[d], out_valid[d], data_out[d]}), 128'(0));
`endif
            end else if (started[d]) begin
                m_rdy = !busy[d];
                check("in_ready", d, 128'(in_ready[d]), 128'(m_rdy));
                if (read_en[d] === 1'b1) begin
                    strobes_seen[d]++;
                    m_ok = busy[d] && (cyc == exp_strobe_cyc[d]);
                    check("strobe_cycle", d, 128'(m_ok), 128'(1));
                    if (m_ok) begin
                        check("address_out", d, 128'(address_out[d]), 128'(exp_addr[d]));
                        exp_q.push_back(mem[exp_addr[d]]);
                        exp_valid_cyc[d] = cyc + m_lat + 1;
                        exp_strobe_cyc[d] = -1;
                    end
                end else if (busy[d] && cyc == exp_strobe_cyc[d]) begin
                    check("strobe_missing", d, 128'(read_en[d]), 128'(1));
                    exp_strobe_cyc[d] = -1;
                end
                if (out_valid[d] === 1'b1) begin
                    if (!in_result[d]) begin
                        check("valid_cycle", d, 128'(cyc), 128'(exp_valid_cyc[d]));
                        in_result[d] = 1'b1;
                        exp_valid_cyc[d] = -1;
                        cur_exp[d] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    end
                    check("dataOut", d, 128'(data_out[d]), 128'(cur_exp[d]));
`ifdef READ_BURST_EN
                    check("out_last", d, 128'(out_last[d]), 128'(beats_left[d] == 0));
`endif
                end else if (exp_valid_cyc[d] >= 0 && cyc >= exp_valid_cyc[d]) begin
                    check("valid_missing", d, 128'(out_valid[d]), 128'(1));
                    exp_valid_cyc[d] = -1;
                end
                // Transfers completing at the coming edge
                if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1 && in_result[d]) begin
                    in_result[d] = 1'b0;
                    if (beats_left[d] > 0) begin
                        beats_left[d]--;
                        exp_addr[d] = exp_addr[d] + 12'd1;
                        exp_strobe_cyc[d] = cyc + 1;
                        strobes_exp[d]++;
                    end else begin
                        busy[d] = 1'b0;
                    end
                end
                if (m_rdy && in_valid[d] === 1'b1) begin
                    busy[d] = 1'b1;
                    exp_addr[d] = address_in[d];
`ifdef READ_BURST_EN
                    beats_left[d] = int'(burst_len[d]);
`else
                    beats_left[d] = 0;
`endif
                    exp_strobe_cyc[d] = cyc + 1;
                    strobes_exp[d]++;
                end
            end
            rst_prev[d] = (rst[d] === 1'b1);
            if (rst[d] === 1'b1) begin
                started[d] = 1'b1;
                busy[d] = 1'b0;
                in_result[d] = 1'b0;
                exp_valid_cyc[d] = -1;
                if (exp_strobe_cyc[d] >= 0) strobes_exp[d]--;
                exp_strobe_cyc[d] = -1;
                beats_left[d] = 0;
                exp_q.delete();
            end
        end
        if (end_req && !end_done) begin
            check("queue_empty", 0, 128'(exp_q.size()), 128'(0));
            for (int d = 0; d < 2; d++) begin
                check("strobe_count", d, 128'(strobes_seen[d]), 128'(strobes_exp[d]));
                check("idle_at_end", d, 128'(busy[d]), 128'(0));
            end
            check("wait_timeouts", 0, 128'(tmo_cnt), 128'(0));
            end_done = 1'b1;
        end
    end

    // Driver tasks
    task automatic req(input int d, input logic [AW-1:0] a, input logic [3:0] bl);
        int n;
        in_valid[d] = 1'b1;
        address_in[d] = a;
`ifdef READ_BURST_EN
        burst_len[d] = bl;
`else
        if (bl != 4'd0) $display("note: burst_len %0d ignored in single-word build", bl);
`endif
        n = 0;
        @(negedge clk);
        while (in_ready[d] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tmo_cnt++;
            $display("FAIL req_timeout dut%0d: in_ready never high, expected 1", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int d);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready[d] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            tmo_cnt++;
            $display("FAIL idle_timeout dut%0d: in_ready never returned, expected 1", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tmo_cnt++;
            $display("FAIL valid_timeout dut%0d: out_valid never high, expected 1", d);
        end
    endtask

    // Stimulus
    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            in_valid[d] = 1'b0;
            address_in[d] = '0;
`ifdef READ_BURST_EN
            burst_len[d] = 4'd0;
`endif
        end
        for (int i = 0; i < 4096; i++) mem[i] = rand_word();
        mem[12'h010] = 108'h123;
        mem[12'h0B0] = 108'hABC;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single read, latency 1
        req(0, 12'h010, 4'd0);
        drop(0);
        wait_idle(0);

        // Single read, latency 3
        req(1, 12'h0A5, 4'd0);
        drop(1);
        wait_idle(1);

        // Backpressure for 10 cycles on a presented word
        bp_mode = 2;
        req(1, 12'h0B0, 4'd0);
        drop(1);
        wait_out_valid(1);
        repeat (10) @(posedge clk);
        #1;
        bp_mode = 0;
        wait_idle(1);

        // Reset during the second WAIT cycle, then a normal request
        req(1, 12'h0C0, 4'd0);
        drop(1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        req(1, 12'h001, 4'd0);
        drop(1);
        wait_idle(1);

        // Back-to-back with in_valid held high
        req(0, 12'h100, 4'd0);
        req(0, 12'h200, 4'd0);
        drop(0);
        wait_idle(0);

`ifdef READ_BURST_EN
        // Burst across the top of the address space
        req(0, 12'hFFE, 4'd2);
        drop(0);
        wait_idle(0);
`endif

        // Randomized traffic with random backpressure
        bp_mode = 1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 25; i++) begin
                req(d, AW'($urandom_range(0, 4095)), 4'($urandom_range(0, 3)));
                drop(d);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            wait_idle(d);
        end
        bp_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        end_req = 1'b1;
        for (int n = 0; n < 10 && !end_done; n++) @(posedge clk);
        if (!end_done) $display("FAIL final_checks: end checks not reached, expected reached");
        $display("test done: total=%0d bad=%0d", total, end_done ? bad : bad + 1);
        $finish;
    end

endmodule

// File: doc/read_memory_controller.md
Name: read_memory_controller

Overview:
- Read-side counterpart to the input-memory write controller in the image accelerator.
- Accepts a read request (address) over a valid/ready handshake and issues a single-cycle read strobe to the pixel memory.
- Waits a fixed memory latency, captures the 108-bit pixel word, and presents it to the downstream consumer over a second valid/ready handshake.

Parameters:
ADD_SIZE, 12, memory address width in bits
DATA_SIZE, 108, memory data word width in bits (9 x 12-bit pixels)
READ_LATENCY, 1, cycles from read_en_out high to dataIn valid; legal range 1..15

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  read request valid
in_ready  output  1  controller can accept a request
address_in  input  ADD_SIZE  request start address
read_en_out  output  1  read strobe to memory
address_out  output  ADD_SIZE  address to memory
dataIn  input  DATA_SIZE  read data from memory
dataOut  output  DATA_SIZE  captured read data to consumer
out_valid  output  1  dataOut valid
out_ready  input  1  consumer accepts dataOut

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- All outputs are registered and never tri-stated.
- Reset values: in_ready=0, read_en_out=0, address_out=0, dataOut=0, out_valid=0. State=IDLE, latency counter=0. in_ready rises the first cycle after rst deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch address_in into addr_reg, drop in_ready, go READ.
  - READ (exactly 1 cycle): read_en_out=1, address_out=addr_reg. Load counter with READ_LATENCY-1, go WAIT.
  - WAIT: read_en_out=0; address_out holds addr_reg. Counter decrements each cycle. When counter==0, sample dataIn into dataOut, set out_valid=1, go RESULT.
  - RESULT: dataOut and out_valid held stable until out_ready. On out_valid&&out_ready, clear out_valid and go IDLE (or READ when a burst beat remains, see below).
- Memory contract: dataIn is valid in the cycle READ_LATENCY cycles after the read_en_out cycle. The controller samples it only at that cycle.
- Latency: request accepted in cycle 0 -> read_en_out in cycle 1 -> out_valid first high in cycle READ_LATENCY+2.
- Throughput: one word per READ_LATENCY+3 cycles when out_ready is held high (IDLE, READ, WAIT xL, RESULT).
- Backpressure: out_ready low holds RESULT indefinitely. No new memory read is issued and dataOut does not change.
- in_valid while in_ready=0: ignored. The requester must hold the request until in_ready.
- out_ready high while out_valid=0: no effect.
- rst asserted in any state: next edge goes to IDLE with reset output values. In-flight memory data is discarded and never presented.
- Exactly one read_en_out pulse per word read.

Optional Feature:
- Macro: READ_BURST_EN.
- Defined:
  - Adds input burst_len [3:0], latched together with address_in. The request reads burst_len+1 consecutive words.
  - Adds output out_last (1 bit), high with the final beat's out_valid.
  - After each RESULT handshake with beats remaining, addr_reg increments by 1, wrapping modulo 2^ADD_SIZE (0xFFF -> 0x000), and the FSM goes directly to READ without returning to IDLE.
  - in_ready stays 0 for the whole burst.
- Undefined: burst_len and out_last ports do not exist, and every request is a single word.

Test Plan:
- Reset then single read, READ_LATENCY=1: request address 0x010 at cycle 0; memory returns 108'h123 -> read_en_out=1 with address_out=0x010 in cycle 1; out_valid=1 with dataOut=108'h123 in cycle 3.
- READ_LATENCY=3: request address 0x0A5 -> exactly one read_en_out pulse; dataIn sampled 3 cycles later; out_valid first high in cycle 5.
- Backpressure: out_ready low for 10 cycles while dataOut=108'hABC -> dataOut and out_valid stable, no extra read_en_out, in_ready=0. Raising out_ready completes the handshake and in_ready=1 on the next cycle.
- Reset mid-WAIT (READ_LATENCY=3, rst high in the 2nd WAIT cycle) -> all outputs 0 on the next cycle, no out_valid for that request; a subsequent request to 0x001 completes normally.
- Back-to-back requests 0x100 then 0x200 with in_valid held high -> second request accepted only after the first handshake; read_en_out pulses exactly twice, in order 0x100, 0x200.
- READ_BURST_EN, burst_len=2 at address 0xFFE -> reads 0xFFE, 0xFFF, 0x000; out_last=1 only on the third beat; then in_ready returns to 1.
